// File: rtl/fetch_queue.sv
// Fetch queue between frontend and decode: circular buffer, no fall-through,
// blocks further fetch once an excepting entry has been accepted.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
    exception_t  ex;
  } fetch_entry_t;
endpackage

module fetch_queue
  import ariane_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fetch_entry_t             fetch_entry_i,
  input  logic                     fetch_entry_valid_i,
  output logic                     fetch_entry_ready_o,
  output fetch_entry_t             fetch_entry_o,
  output logic                     fetch_entry_valid_o,
  input  logic                     fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ex_pending_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;
  logic            r_ex_pending;
  fetch_entry_t    r_mem [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_unused_cfg;

  assign w_unused_cfg = ^CVA6Cfg;

  // Ready looks only at registered state and flush, never at decode ready.
  assign fetch_entry_ready_o = (r_count != CntW'(DEPTH))
                            && !r_ex_pending && !flush_i;
  assign fetch_entry_valid_o = (r_count != '0);
  assign fetch_entry_o       = r_mem[r_rd_ptr];
  assign count_o             = r_count;
  assign ex_pending_o        = r_ex_pending;

  assign w_push = fetch_entry_valid_i && fetch_entry_ready_o;
  assign w_pop  = fetch_entry_valid_o && fetch_entry_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= fetch_entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_ex_pending <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_ex_pending <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && fetch_entry_i.ex.valid) begin
        r_ex_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: per-cycle vector table with a data scoreboard,
// plus reset checks.
module tb_fetch_queue;
  import ariane_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  fetch_entry_t fe_i;
  logic         valid_i;
  logic         ready_o;
  fetch_entry_t fe_o;
  logic         valid_o;
  logic         ready_i;
  logic [2:0]   count_o;
  logic         ex_o;

  fetch_queue #(.DEPTH(4)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .fetch_entry_i       (fe_i),
    .fetch_entry_valid_i (valid_i),
    .fetch_entry_ready_o (ready_o),
    .fetch_entry_o       (fe_o),
    .fetch_entry_valid_o (valid_o),
    .fetch_entry_ready_i (ready_i),
    .count_o             (count_o),
    .ex_pending_o        (ex_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          v;
    logic [31:0] a;
    bit          ex;
    bit          rdy;
    bit          fl;
    int          cnt;
    bit          erdy;
    bit          eval;
    bit          eex;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(bit v, logic [31:0] a, bit ex, bit rdy, bit fl,
                     int cnt, bit erdy, bit eval, bit eex);
    vec_t t;
    t = '{v: v, a: a, ex: ex, rdy: rdy, fl: fl,
          cnt: cnt, erdy: erdy, eval: eval, eex: eex};
    vecs.push_back(t);
  endtask

  task automatic drive(vec_t t);
    fe_i.address     = t.a;
    fe_i.instruction = ~t.a;
    fe_i.ex.cause    = t.a ^ 32'h5a5a_0000;
    fe_i.ex.tval     = t.a + 32'h10;
    fe_i.ex.valid    = t.ex;
    valid_i          = t.v;
    ready_i          = t.rdy;
    flush_i          = t.fl;
  endtask

  task automatic apply(int idx, vec_t t);
    logic [31:0] exp_a;
    drive(t);
    @(negedge clk_i);
    chk("count_o", idx, 32'(count_o), 32'(t.cnt));
    chk("ready_o", idx, 32'(ready_o), 32'(t.erdy));
    chk("valid_o", idx, 32'(valid_o), 32'(t.eval));
    chk("ex_pending_o", idx, 32'(ex_o), 32'(t.eex));
    if (t.eval && t.rdy) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard row %0d: pop with nothing expected", idx);
      end else begin
        exp_a = sb.pop_front();
        chk("head_addr", idx, fe_o.address, exp_a);
        chk("head_instr", idx, fe_o.instruction, ~exp_a);
      end
    end
    if (t.v && t.erdy) sb.push_back(t.a);
    if (t.fl) sb.delete();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = '{v: 0, a: 0, ex: 0, rdy: 0, fl: 0,
             cnt: 0, erdy: 1, eval: 0, eex: 0};
    rst_ni = 1'b0;
    drive(idle);
    @(negedge clk_i);
    chk("rst_valid_o", -1, 32'(valid_o), 32'd0);
    chk("rst_ready_o", -1, 32'(ready_o), 32'd1);
    chk("rst_count_o", -1, 32'(count_o), 32'd0);
    chk("rst_ex_o", -1, 32'(ex_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++)
      add(1, 32'h8000_0000 + 32'(4 * i), 0, 0, 0, i, 1, i != 0, 0);
    add(0, 0, 0, 0, 0, 4, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 1, 0, 4 - i, i != 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // No fall-through on an empty queue.
    add(1, 32'hA000_0000, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Streaming push+pop across several pointer wraps.
    for (int i = 0; i < 13; i++)
      add(1, 32'hB000_0000 + 32'(4 * i), 0, 1, 0, i == 0 ? 0 : 1, 1, i != 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Push+pop at DEPTH-1, then pop while full blocks the push.
    for (int i = 0; i < 3; i++)
      add(1, 32'hC000_0000 + 32'(4 * i), 0, 0, 0, i, 1, i != 0, 0);
    add(1, 32'hC000_0100, 0, 1, 0, 3, 1, 1, 0);
    add(1, 32'hC000_0104, 0, 1, 0, 3, 1, 1, 0);
    add(1, 32'hC000_0108, 0, 0, 0, 3, 1, 1, 0);
    add(1, 32'hC000_010C, 0, 1, 0, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 1, 0, 3 - i, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Exception entry blocks the queue until flush; pop during flush.
    add(1, 32'hE000_0000, 1, 0, 0, 0, 1, 0, 0);
    add(1, 32'hE000_0004, 0, 0, 0, 1, 0, 1, 1);
    add(1, 32'hE000_0008, 0, 0, 0, 1, 0, 1, 1);
    add(1, 32'hE000_000C, 0, 1, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Flush blocks a push in its own cycle.
    add(1, 32'hD000_0000, 0, 0, 0, 0, 1, 0, 0);
    add(1, 32'hD000_0004, 0, 0, 0, 1, 1, 1, 0);
    add(1, 32'hD000_0008, 0, 0, 1, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Fill to three ahead of the async reset check.
    for (int i = 0; i < 3; i++)
      add(1, 32'hF000_0000 + 32'(4 * i), 0, 0, 0, i, 1, i != 0, 0);
    add(0, 0, 0, 0, 0, 3, 1, 1, 0);

    foreach (vecs[i]) apply(i, vecs[i]);

    drive(idle);
    chk("pre_rst_count", -2, 32'(count_o), 32'd3);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid_o", -2, 32'(valid_o), 32'd0);
    chk("async_rst_count_o", -2, 32'(count_o), 32'd0);
    chk("async_rst_ready_o", -2, 32'(ready_o), 32'd1);
    sb.delete();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    apply(-3, idle);
    chk("sb_empty", -4, 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning the core configuration.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of entries; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have port clk_i, input, 1 bit: clock. Reset is rst_ni, asynchronous, active-low; clock is clk_i.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit: discard all stored entries.
REQ-006 The block SHALL have port fetch_entry_i, input, ariane_pkg::fetch_entry_t: entry from the frontend.
REQ-007 The block SHALL have port fetch_entry_valid_i, input, 1 bit: the frontend entry is valid.
REQ-008 The block SHALL have port fetch_entry_ready_o, output, 1 bit: the queue accepts the entry this cycle.
REQ-009 The block SHALL have port fetch_entry_o, output, ariane_pkg::fetch_entry_t: head entry presented to decode.
REQ-010 The block SHALL have port fetch_entry_valid_o, output, 1 bit: the head entry is valid.
REQ-011 The block SHALL have port fetch_entry_ready_i, input, 1 bit: decode consumes the head entry.
REQ-012 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 The block SHALL have port ex_pending_o, output, 1 bit: an entry carrying an exception has been accepted and the queue is blocked.

Function
REQ-014 Storage SHALL be a circular buffer with read pointer, write pointer (each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0) and a count register.
REQ-015 Push SHALL occur when fetch_entry_valid_i && fetch_entry_ready_o; pop SHALL occur when fetch_entry_valid_o && fetch_entry_ready_i.
REQ-016 fetch_entry_ready_o SHALL be (count_q != DEPTH) && !ex_pending_q && !flush_i; it SHALL have no combinational dependence on fetch_entry_ready_i.
REQ-017 fetch_entry_valid_o SHALL be (count_q != 0); fetch_entry_o SHALL be mem[rd_ptr_q].
REQ-018 There SHALL be no fall-through: an entry pushed in cycle N becomes visible at the output no earlier than cycle N+1.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when count is DEPTH-1 or 1.
REQ-020 When full, a pop SHALL NOT enable a push in the same cycle; ready_o rises in the following cycle.
REQ-021 Pushing an entry with ex.valid=1 SHALL set ex_pending_q the next cycle; while it is set, ready_o SHALL be 0.
REQ-022 ex_pending_q SHALL clear only on flush_i.
REQ-023 flush_i SHALL, in the next cycle, zero the pointers, count and ex_pending_q, and SHALL block any push in the flush cycle.
REQ-024 A pop coinciding with flush_i SHALL be allowed (decode sees valid) but has no effect beyond the flush.
REQ-025 Storage array contents SHALL NOT require reset; only control state is reset.
REQ-026 count_o SHALL equal count_q; ex_pending_o SHALL equal ex_pending_q.

Reset
REQ-027 While rst_ni=0, pointers, count and ex_pending SHALL be 0, giving fetch_entry_valid_o=0, fetch_entry_ready_o=1, count_o=0, ex_pending_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously.

Verification
REQ-029 Push addresses 0x80000000, 0x80000004, 0x80000008, 0x8000000C with ready_i=0, DEPTH=4 -> count_o=4, ready_o=0; then ready_i=1 -> the same four addresses are output in order, one per cycle.
REQ-030 Push in cycle N on an empty queue -> valid_o=0 in cycle N and valid_o=1 with that entry in cycle N+1.
REQ-031 Continuous push and pop for 3*DEPTH entries -> count stays constant and all entries are in order (covers pointer wrap).
REQ-032 Push an entry with ex.valid=1 followed by more valid inputs -> ex_pending_o=1, ready_o=0, the later inputs are not accepted; flush_i -> count_o=0, ex_pending_o=0, ready_o=1.
REQ-033 Full queue with pop and valid input in the same cycle -> no push that cycle, count_o=3, ready_o=1 in the next cycle.
REQ-034 rst_ni pulsed low with count_o=3 -> valid_o=0 and count_o=0 before the next clock edge.
